// File: rtl/nbit_register_pkg.sv
// nbit_register_pkg: shared constants for the lab register file building blocks
package nbit_register_pkg;
    localparam int unsigned NBIT_DEFAULT_W = 4;
endpackage

// File: rtl/nbit_register_dff_async_clr.sv
// dff_async_clr: 1-bit D flip-flop with asynchronous active-low clear
module dff_async_clr (
    input  logic Clock,
    input  logic Clear,
    input  logic d,
    output logic q
);
    always_ff @(posedge Clock or negedge Clear)
        if (!Clear) q <= 1'b0;
        else        q <= d;
endmodule

// File: rtl/nbit_register.sv
// nbit_register: N-bit register loading every rising edge, async active-low clear
module nbit_register
    import nbit_register_pkg::*;
#(
    parameter int N = NBIT_DEFAULT_W
) (
    input  logic         Clock,
    input  logic         Clear,
    input  logic [N-1:0] Data_in,
    output logic [N-1:0] Data_out
);
    for (genvar i = 0; i < N; i++) begin : g_bit
        dff_async_clr u_dff (
            .Clock (Clock),
            .Clear (Clear),
            .d     (Data_in[i]),
            .q     (Data_out[i])
        );
    end
endmodule

// File: tb/tb_nbit_register.sv
// tb_nbit_register: directed checks of nbit_register at N=4 and N=8
module tb_nbit_register;
    logic       clk = 1'b0;
    logic       clr4, clr8;
    logic [3:0] d4, q4;
    logic [7:0] d8, q8;
    logic [4:0] wide;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nbit_register u_dut4 (
        .Clock    (clk),
        .Clear    (clr4),
        .Data_in  (d4),
        .Data_out (q4)
    );

    nbit_register #(.N(8)) u_dut8 (
        .Clock    (clk),
        .Clear    (clr8),
        .Data_in  (d8),
        .Data_out (q8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr4 = 1'b0;
        clr8 = 1'b0;
        d4   = 4'hF;
        d8   = 8'h00;
        #1;
        check("reset_async", {4'h0, q4}, 8'h00);
        tick(); check("reset_hold_e1", {4'h0, q4}, 8'h00);
        tick(); check("reset_hold_e2", {4'h0, q4}, 8'h00);
        tick(); check("reset_hold_e3", {4'h0, q4}, 8'h00);
        @(negedge clk);
        clr4 = 1'b1;
        #1;
        check("release_no_load", {4'h0, q4}, 8'h00);
        tick(); check("first_load_F", {4'h0, q4}, 8'h0F);

        @(negedge clk);
        d4 = 4'd10;
        tick(); check("load_10", {4'h0, q4}, 8'h0A);
        #2;
        d4 = 4'd9;
        @(negedge clk); #1;
        check("no_change_falling", {4'h0, q4}, 8'h0A);
        tick(); check("load_9", {4'h0, q4}, 8'h09);

        @(negedge clk);
        clr4 = 1'b0;
        #1;
        check("clear_midcycle", {4'h0, q4}, 8'h00);
        d4 = 4'd5;
        tick(); check("clear_hold_e1", {4'h0, q4}, 8'h00);
        tick(); check("clear_hold_e2", {4'h0, q4}, 8'h00);
        @(negedge clk);
        clr4 = 1'b1;
        #1;
        check("release2_no_load", {4'h0, q4}, 8'h00);
        tick(); check("load_5_after_release", {4'h0, q4}, 8'h05);

        wide = 5'd16;
        d4 = 4'(wide);
        tick(); check("truncate_16", {4'h0, q4}, 8'h00);

        d4 = 4'd3;
        tick(); check("load_3", {4'h0, q4}, 8'h03);
        #2;
        d4 = 4'hC;
        #1;
        check("no_comb_path", {4'h0, q4}, 8'h03);

        @(posedge clk);
        clr4 = 1'b0;
        #1;
        check("clear_at_edge", {4'h0, q4}, 8'h00);

        @(negedge clk);
        clr8 = 1'b1;
        d8 = 8'hA5;
        #1;
        check("n8_release_no_load", q8, 8'h00);
        tick(); check("n8_load_A5", q8, 8'hA5);
        @(negedge clk);
        d8 = 8'h5A;
        tick(); check("n8_load_5A", q8, 8'h5A);
        @(negedge clk);
        clr8 = 1'b0;
        #1;
        check("n8_clear", q8, 8'h00);
        tick(); check("n8_clear_hold", q8, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
